// File: rtl/stream_capture_fifo.sv
// stream_capture_fifo
// Captures a muxed byte stream into a first-word fall-through FIFO and keeps
// per-packet statistics: length, source select, running count, source-change
// errors and, optionally, an XOR checksum.
// Optional feature macro: STREAM_CAPTURE_CHKSUM_EN (XOR checksum on pkt_chk;
// when undefined pkt_chk is tied to 8'h00 and no accumulator is built).

module stream_capture_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        sel,
   input  logic [7:0]        s_tdata,
   input  logic              s_tvalid,
   input  logic              s_tlast,
   output logic              s_tready,
   output logic [7:0]        m_tdata,
   output logic              m_tvalid,
   output logic              m_tlast,
   input  logic              m_tready,
   output logic [ADDR_W:0]   level,
   output logic              pkt_done,
   output logic [7:0]        pkt_len,
   output logic [2:0]        pkt_src,
   output logic [15:0]       pkt_cnt,
   output logic              src_err,
   output logic [7:0]        pkt_chk
);

   typedef enum logic {
      IDLE,
      IN_PKT
   } pktState_e;

   localparam logic [ADDR_W:0] FullLevel = (ADDR_W+1)'(DEPTH);

   logic [8:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] wrPtr_q;
   logic [ADDR_W-1:0] rdPtr_q;
   logic [ADDR_W:0]   level_q;
   logic [ADDR_W:0]   level_d;
   logic              wrEn;
   logic              rdEn;

   pktState_e         state_q;
   pktState_e         state_d;
   logic [7:0]        beatCnt_q;
   logic [7:0]        beatCnt_d;
   logic [2:0]        srcReg_q;
   logic [2:0]        srcReg_d;
   logic              pktComplete;
   logic              srcMismatch;

   logic              pktDone_q;
   logic              srcErr_q;
   logic [7:0]        pktLen_q;
   logic [2:0]        pktSrc_q;
   logic [15:0]       pktCnt_q;

   // Handshakes come only from the registered level, so ready/valid never
   // depend combinationally on the opposite side of the FIFO.
   assign s_tready = (level_q != FullLevel);
   assign m_tvalid = (level_q != '0);
   assign wrEn     = s_tvalid && s_tready;
   assign rdEn     = m_tvalid && m_tready;

   // Fall-through read: the head entry is always visible on the output.
   assign {m_tlast, m_tdata} = mem_q[rdPtr_q];
   assign level    = level_q;

   assign pkt_done = pktDone_q;
   assign src_err  = srcErr_q;
   assign pkt_len  = pktLen_q;
   assign pkt_src  = pktSrc_q;
   assign pkt_cnt  = pktCnt_q;

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (wrEn) begin
         mem_q[wrPtr_q] <= {s_tlast, s_tdata};
      end
   end

   // Occupancy bookkeeping: a simultaneous read and write cancel out.
   always_comb begin
      level_d = level_q;
      case ({wrEn, rdEn})
         2'b10:   level_d = level_q + (ADDR_W+1)'(1);
         2'b01:   level_d = level_q - (ADDR_W+1)'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointer and level registers; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else begin
         if (wrEn) begin
            wrPtr_q <= wrPtr_q + ADDR_W'(1);
         end
         if (rdEn) begin
            rdPtr_q <= rdPtr_q + ADDR_W'(1);
         end
         level_q <= level_d;
      end
   end

   // Packet FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Packet FSM next state: only accepted input beats move the machine.
   always_comb begin
      state_d = state_q;
      if (wrEn) begin
         case (state_q)
            IDLE:    state_d = s_tlast ? IDLE : IN_PKT;
            IN_PKT:  state_d = s_tlast ? IDLE : IN_PKT;
            default: state_d = IDLE;
         endcase
      end
   end

   // Packet FSM outputs: beat count, source latch, completion and source-change flags.
   always_comb begin
      beatCnt_d   = beatCnt_q;
      srcReg_d    = srcReg_q;
      pktComplete = 1'b0;
      srcMismatch = 1'b0;
      if (wrEn) begin
         pktComplete = s_tlast;
         if (state_q == IDLE) begin
            beatCnt_d = 8'd1;
            srcReg_d  = sel;
         end else begin
            beatCnt_d   = (beatCnt_q == 8'hFF) ? 8'hFF : beatCnt_q + 8'd1;
            srcMismatch = (sel != srcReg_q);
         end
      end
   end

   // Packet statistics registers; reset discards any partial packet silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         beatCnt_q <= '0;
         srcReg_q  <= '0;
         pktDone_q <= 1'b0;
         srcErr_q  <= 1'b0;
         pktLen_q  <= '0;
         pktSrc_q  <= '0;
         pktCnt_q  <= '0;
      end else begin
         beatCnt_q <= beatCnt_d;
         srcReg_q  <= srcReg_d;
         pktDone_q <= pktComplete;
         srcErr_q  <= srcMismatch;
         if (pktComplete) begin
            pktLen_q <= beatCnt_d;
            pktSrc_q <= srcReg_d;
            pktCnt_q <= pktCnt_q + 16'd1;
         end
      end
   end

`ifdef STREAM_CAPTURE_CHKSUM_EN
   logic [7:0] chkAcc_q;
   logic [7:0] chkAcc_d;
   logic [7:0] pktChk_q;

   // Running XOR restarts with the first byte of each packet.
   always_comb begin
      chkAcc_d = chkAcc_q;
      if (wrEn) begin
         chkAcc_d = (state_q == IDLE) ? s_tdata : (chkAcc_q ^ s_tdata);
      end
   end

   // Checksum registers; the reported value includes the final beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         chkAcc_q <= '0;
         pktChk_q <= '0;
      end else begin
         chkAcc_q <= chkAcc_d;
         if (pktComplete) begin
            pktChk_q <= chkAcc_d;
         end
      end
   end

   assign pkt_chk = pktChk_q;
`else
   assign pkt_chk = 8'h00;
`endif

endmodule

// File: tb/tb_stream_capture_fifo.sv
// tb_stream_capture_fifo
// Directed bench for stream_capture_fifo with a queue-based reference model
// compared against the DUT every cycle, plus literal spot checks.
// Honours STREAM_CAPTURE_CHKSUM_EN the same way the design does.

module tb_stream_capture_fifo;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  sel;
   logic [7:0]  s_tdata;
   logic        s_tvalid;
   logic        s_tlast;
   logic        s_tready;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_tlast;
   logic        m_tready;
   logic [4:0]  level;
   logic        pkt_done;
   logic [7:0]  pkt_len;
   logic [2:0]  pkt_src;
   logic [15:0] pkt_cnt;
   logic        src_err;
   logic [7:0]  pkt_chk;

   int total = 0;
   int bad   = 0;
   bit checkEn = 1'b0;

   // Reference model state: FIFO contents as a queue, current packet as a byte list.
   logic [8:0]  modelQ[$];
   logic [7:0]  pktBytes[$];
   bit          inPkt;
   logic [2:0]  curSrc;
   bit          expDone;
   bit          expErr;
   logic [7:0]  expLen;
   logic [2:0]  expSrc;
   logic [15:0] expCnt;
   logic [7:0]  expChk;

   // 100 MHz style free-running clock.
   always #5 clk = ~clk;

   stream_capture_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .sel      (sel),
      .s_tdata  (s_tdata),
      .s_tvalid (s_tvalid),
      .s_tlast  (s_tlast),
      .s_tready (s_tready),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tlast  (m_tlast),
      .m_tready (m_tready),
      .level    (level),
      .pkt_done (pkt_done),
      .pkt_len  (pkt_len),
      .pkt_src  (pkt_src),
      .pkt_cnt  (pkt_cnt),
      .src_err  (src_err),
      .pkt_chk  (pkt_chk)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Offers one beat and holds it until the FIFO takes it (bounded wait).
   task automatic applyStimulus(input logic [7:0] data, input logic last, input logic [2:0] src);
      bit took;
      took     = 1'b0;
      s_tdata  = data;
      s_tlast  = last;
      sel      = src;
      s_tvalid = 1'b1;
      for (int k = 0; k < 100 && !took; k++) begin
         took = s_tready;
         @(posedge clk);
         #2;
      end
      if (!took) begin
         checkOutput("accept_timeout", 0, 1);
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   // Idles the input side until the FIFO drains (bounded wait).
   task automatic waitEmpty();
      for (int k = 0; k < 100 && level != 0; k++) begin
         @(posedge clk);
         #2;
      end
      checkOutput("drain", level, 0);
   endtask

   // Behavioural model: decides acceptance from occupancy and rebuilds packet stats from the byte list.
   always @(posedge clk) begin : model
      bit         takeIn;
      bit         takeOut;
      logic [7:0] x;
      if (rst) begin
         modelQ.delete();
         pktBytes.delete();
         inPkt   = 1'b0;
         curSrc  = '0;
         expDone = 1'b0;
         expErr  = 1'b0;
         expLen  = '0;
         expSrc  = '0;
         expCnt  = '0;
         expChk  = '0;
      end else begin
         takeIn  = s_tvalid && (modelQ.size() < DEPTH);
         takeOut = m_tready && (modelQ.size() > 0);
         expDone = 1'b0;
         expErr  = 1'b0;
         if (takeOut) begin
            void'(modelQ.pop_front());
         end
         if (takeIn) begin
            modelQ.push_back({s_tlast, s_tdata});
            if (!inPkt) begin
               inPkt  = 1'b1;
               curSrc = sel;
               pktBytes.delete();
            end else if (sel != curSrc) begin
               expErr = 1'b1;
            end
            pktBytes.push_back(s_tdata);
            if (s_tlast) begin
               expDone = 1'b1;
               expLen  = (pktBytes.size() > 255) ? 8'd255 : 8'(pktBytes.size());
               expSrc  = curSrc;
               expCnt  = expCnt + 16'd1;
               x = 8'h00;
`ifdef STREAM_CAPTURE_CHKSUM_EN
               foreach (pktBytes[i]) x = x ^ pktBytes[i];
`endif
               expChk = x;
               inPkt  = 1'b0;
            end
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model, away from the active edge.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("level", 32'(level), modelQ.size());
         checkOutput("s_tready", 32'(s_tready), 32'(modelQ.size() != DEPTH));
         checkOutput("m_tvalid", 32'(m_tvalid), 32'(modelQ.size() != 0));
         if (modelQ.size() != 0) begin
            checkOutput("m_head", {m_tlast, m_tdata}, modelQ[0]);
         end
         checkOutput("pkt_done", 32'(pkt_done), 32'(expDone));
         checkOutput("src_err", 32'(src_err), 32'(expErr));
         checkOutput("pkt_len", 32'(pkt_len), 32'(expLen));
         checkOutput("pkt_src", 32'(pkt_src), 32'(expSrc));
         checkOutput("pkt_cnt", 32'(pkt_cnt), 32'(expCnt));
         checkOutput("pkt_chk", 32'(pkt_chk), 32'(expChk));
      end
   end

   // Directed scenario sequence with literal spot checks after key beats.
   initial begin
      logic [7:0] chkWant;
      rst      = 1'b1;
      sel      = '0;
      s_tdata  = '0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      m_tready = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #2;
      end
      checkEn = 1'b1;
      checkOutput("rst_level", 32'(level), 0);
      checkOutput("rst_m_tvalid", 32'(m_tvalid), 0);
      checkOutput("rst_s_tready", 32'(s_tready), 1);
      checkOutput("rst_pkt_cnt", 32'(pkt_cnt), 0);
      rst = 1'b0;

      // Single-beat packet straight through.
      m_tready = 1'b1;
      applyStimulus(8'hA5, 1'b1, 3'd3);
      checkOutput("single_done", 32'(pkt_done), 1);
      checkOutput("single_len", 32'(pkt_len), 1);
      checkOutput("single_src", 32'(pkt_src), 3);
      checkOutput("single_cnt", 32'(pkt_cnt), 1);
      checkOutput("single_data", 32'(m_tdata), 32'hA5);
      checkOutput("single_last", 32'(m_tlast), 1);
      @(posedge clk);
      #2;
      checkOutput("single_done_drop", 32'(pkt_done), 0);
      checkOutput("single_empty", 32'(level), 0);

      // Fill to full with the sink stalled, then release.
      m_tready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(8'(i), 1'b0, 3'd2);
      end
      s_tdata  = 8'd16;
      s_tvalid = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #2;
      end
      checkOutput("full_level", 32'(level), 16);
      checkOutput("full_ready", 32'(s_tready), 0);
      checkOutput("full_head", 32'(m_tdata), 0);
      m_tready = 1'b1;
      for (int i = 16; i < 20; i++) begin
         applyStimulus(8'(i), (i == 19), 3'd2);
      end
      checkOutput("full_pkt_len", 32'(pkt_len), 20);
      checkOutput("full_pkt_cnt", 32'(pkt_cnt), 2);
      waitEmpty();

      // Hold level at 8 with simultaneous read and write so both pointers wrap.
      m_tready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(8'(i), 1'b0, 3'd4);
      end
      m_tready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         applyStimulus(8'(8 + i), (i == 49), 3'd4);
         checkOutput("steady_level", 32'(level), 8);
         checkOutput("steady_valid", 32'(m_tvalid), 1);
      end
      checkOutput("steady_pkt_len", 32'(pkt_len), 58);
      waitEmpty();

      // Idle select wiggle is ignored; source change on beat 3 only.
      sel = 3'd5;
      @(posedge clk);
      #2;
      applyStimulus(8'h10, 1'b0, 3'd1);
      applyStimulus(8'h11, 1'b0, 3'd1);
      applyStimulus(8'h12, 1'b0, 3'd2);
      checkOutput("srcchg_err", 32'(src_err), 1);
      applyStimulus(8'h13, 1'b1, 3'd1);
      checkOutput("srcchg_err_drop", 32'(src_err), 0);
      checkOutput("srcchg_done", 32'(pkt_done), 1);
      checkOutput("srcchg_len", 32'(pkt_len), 4);
      checkOutput("srcchg_src", 32'(pkt_src), 1);

      // Checksum packet.
      applyStimulus(8'h01, 1'b0, 3'd5);
      applyStimulus(8'h02, 1'b0, 3'd5);
      applyStimulus(8'h04, 1'b0, 3'd5);
      applyStimulus(8'h08, 1'b1, 3'd5);
`ifdef STREAM_CAPTURE_CHKSUM_EN
      chkWant = 8'h0F;
`else
      chkWant = 8'h00;
`endif
      checkOutput("chk_value", 32'(pkt_chk), 32'(chkWant));
      waitEmpty();

      // Reset in the middle of a packet discards it.
      m_tready = 1'b0;
      applyStimulus(8'h20, 1'b0, 3'd3);
      applyStimulus(8'h21, 1'b0, 3'd3);
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      checkOutput("midrst_level", 32'(level), 0);
      checkOutput("midrst_done", 32'(pkt_done), 0);
      checkOutput("midrst_cnt", 32'(pkt_cnt), 0);
      m_tready = 1'b1;
      applyStimulus(8'h30, 1'b0, 3'd4);
      applyStimulus(8'h31, 1'b0, 3'd4);
      applyStimulus(8'h32, 1'b1, 3'd4);
      checkOutput("midrst_len", 32'(pkt_len), 3);
      checkOutput("midrst_src", 32'(pkt_src), 4);
      checkOutput("midrst_pkt_cnt", 32'(pkt_cnt), 1);

      // Long packet: beat counter saturates at 255.
      for (int i = 0; i < 260; i++) begin
         applyStimulus(8'(i), (i == 259), 3'd2);
      end
      checkOutput("sat_len", 32'(pkt_len), 255);
      checkOutput("sat_cnt", 32'(pkt_cnt), 2);
      waitEmpty();

      repeat (2) begin
         @(posedge clk);
         #2;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
